// File: rtl/mmio_port_responder.sv
// MMIO responder owning PortOut, a synchronized PortIn view, a sticky change flag and a change counter.
// Define MMIO_PORT_IRQ_EN to add the irq output and the STATUS.IRQ_ENABLE bit.
//
// state | meaning
// IDLE  | waiting for a selected read or write request
// WAIT  | burning the programmed wait states
// RESP  | Ready high, read data driven, write committed at the closing edge
// GAP   | dead cycle while the initiator drops its request
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDR     = 32'h1001_0000,
   parameter int          WAIT_STATES   = 1,
   parameter int          PORT_IN_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     MemRead,
   input  logic                     MemWrite,
   input  logic [31:0]              Address,
   input  logic [31:0]              WriteData,
   output logic [31:0]              ReadData,
   output logic                     Ready,
   input  logic [PORT_IN_WIDTH-1:0] PortIn,
`ifdef MMIO_PORT_IRQ_EN
   output logic                     irq,
`endif
   output logic [31:0]              PortOut
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   localparam logic [27:0] BASE_HI   = BASE_ADDR[31:4];
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]               state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [1:0]               off_q, off_d;
   logic                     wr_q, wr_d;
   logic [31:0]              wdata_q, wdata_d;
   logic [31:0]              port_out_q, port_out_d;
   logic [PORT_IN_WIDTH-1:0] sync1_q, sync1_d;
   logic [PORT_IN_WIDTH-1:0] sync2_q, sync2_d;
   logic [PORT_IN_WIDTH-1:0] prev_q, prev_d;
   logic                     changed_q, changed_d;
   logic [15:0]              edge_cnt_q, edge_cnt_d;
   logic                     irq_en_q;

   logic        sel;
   logic        resp;
   logic        wr_out;
   logic        wr_stat;
   logic        wr_cnt;
   logic        change;
   logic [31:0] port_in_ext;
   logic [31:0] status;
   logic [31:0] rd_mux;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^Address[1:0];
   assign sel     = (Address[31:4] == BASE_HI);
   assign resp    = (state_q == S_RESP);
   assign wr_out  = resp && wr_q && (off_q == 2'd0);
   assign wr_stat = resp && wr_q && (off_q == 2'd2);
   assign wr_cnt  = resp && wr_q && (off_q == 2'd3);
   assign change  = (sync2_q != prev_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (sel && (MemRead || MemWrite)) begin
               off_d   = Address[3:2];
               wr_d    = MemWrite;
               wdata_d = WriteData;
               if (WAIT_STATES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP:  state_d = S_GAP;
         default: state_d = S_IDLE;
      endcase
   end

   // Set beats clear: a change seen in the same cycle as a W1C or counter clear survives.
   always_comb begin
      sync1_d    = PortIn;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      port_out_d = wr_out ? wdata_q : port_out_q;
      changed_d  = change | (changed_q & ~(wr_stat & wdata_q[0]));
      edge_cnt_d = edge_cnt_q;
      if (wr_cnt)
         edge_cnt_d = {15'd0, change};
      else if (change && (edge_cnt_q != 16'hFFFF))
         edge_cnt_d = edge_cnt_q + 16'd1;
   end

   always_comb begin
      port_in_ext                      = '0;
      port_in_ext[PORT_IN_WIDTH-1:0]   = sync2_q;
      status                           = {30'd0, irq_en_q, changed_q};
      rd_mux                           = '0;
      case (off_q)
         2'd0:    rd_mux = port_out_q;
         2'd1:    rd_mux = port_in_ext;
         2'd2:    rd_mux = status;
         default: rd_mux = {16'd0, edge_cnt_q};
      endcase
   end

   assign Ready    = resp;
   assign ReadData = (resp && !wr_q) ? rd_mux : 32'd0;
   assign PortOut  = port_out_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         off_q      <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         port_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         changed_q  <= 1'b0;
         edge_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         off_q      <= off_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         port_out_q <= port_out_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         changed_q  <= changed_d;
         edge_cnt_q <= edge_cnt_d;
      end
   end

`ifdef MMIO_PORT_IRQ_EN
   logic irq_en_d;
   logic irq_q, irq_d;

   always_comb begin
      irq_en_d = wr_stat ? wdata_q[1] : irq_en_q;
      irq_d    = changed_q & irq_en_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq_en_q = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: vector table, directed corner sequences, randomized traffic vs a register-level model.
module tb_mmio_port_responder;
   localparam logic [31:0] BASE = 32'h1001_0000;
   localparam int          WS   = 1;
   localparam int          PW   = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          MemRead, MemWrite;
   logic [31:0]   Address, WriteData;
   logic [31:0]   ReadData;
   logic          Ready;
   logic [PW-1:0] PortIn;
   logic [31:0]   PortOut;
`ifdef MMIO_PORT_IRQ_EN
   logic          irq;
`endif

   always #5 clk = ~clk;

   mmio_port_responder #(.BASE_ADDR(BASE), .WAIT_STATES(WS), .PORT_IN_WIDTH(PW)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .Ready(Ready),
      .PortIn(PortIn),
`ifdef MMIO_PORT_IRQ_EN
      .irq(irq),
`endif
      .PortOut(PortOut));

   int checks = 0;
   int errors = 0;

   // register-level model
   logic [31:0]   m_port_out;
   logic          m_changed;
   int            m_cnt;
   logic [PW-1:0] m_pin;
   logic          m_irq_en;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [31:0] exp_pout;
      string       name;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_port_out = '0; m_changed = 1'b0; m_cnt = 0; m_pin = '0; m_irq_en = 1'b0;
   endfunction

   function automatic void model_write(input logic [1:0] off, input logic [31:0] d);
      case (off)
         2'd0: m_port_out = d;
         2'd2: begin
            if (d[0]) m_changed = 1'b0;
`ifdef MMIO_PORT_IRQ_EN
            m_irq_en = d[1];
`endif
         end
         2'd3: m_cnt = 0;
         default: ;
      endcase
   endfunction

   function automatic void model_pin(input logic [PW-1:0] v);
      if (v != m_pin) begin
         m_changed = 1'b1;
         if (m_cnt < 65535) m_cnt++;
      end
      m_pin = v;
   endfunction

   function automatic logic [31:0] exp_reg(input logic [1:0] off);
      case (off)
         2'd0:    return m_port_out;
         2'd1:    return 32'(m_pin);
         2'd2:    return {30'd0, m_irq_en, m_changed};
         default: return 32'(m_cnt);
      endcase
   endfunction

   task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int max_cyc, output logic [31:0] rdata, output int lat, output logic proto_err);
      bit got;
      got = 0; lat = 0; rdata = '0; proto_err = 1'b0;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; Address = addr; WriteData = wdata;
      while (!got && lat < max_cyc) begin
         @(posedge clk); #1;
         lat++;
         if (Ready) begin
            got = 1; rdata = ReadData;
         end else if (ReadData !== 32'd0) proto_err = 1'b1;
      end
      MemRead = 1'b0; MemWrite = 1'b0;
      @(posedge clk); #1;
      if (Ready !== 1'b0 || ReadData !== 32'd0) proto_err = 1'b1;
      @(posedge clk); #1;
      if (!got) lat = -1;
   endtask

   task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
      logic [31:0] rd; int lat; logic pe;
      access(1'b1, 1'b0, addr, 32'd0, 20, rd, lat, pe);
      chk({name, " latency"}, 32'(lat), 32'(WS + 1));
      chk(name, rd, exp);
      chk({name, " protocol"}, {31'd0, pe}, 32'd0);
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] d, input logic also_rd, input string name);
      logic [31:0] rd; int lat; logic pe;
      access(also_rd, 1'b1, addr, d, 20, rd, lat, pe);
      model_write(addr[3:2], d);
      chk({name, " latency"}, 32'(lat), 32'(WS + 1));
      chk({name, " rdata"}, rd, 32'd0);
      chk({name, " PortOut"}, PortOut, m_port_out);
   endtask

   task automatic set_pin(input logic [PW-1:0] v);
      @(negedge clk);
      PortIn = v;
      model_pin(v);
      repeat (4) @(posedge clk);
      #1;
   endtask

   // PortIn moves on the same edge the request is sampled, so with one wait state the
   // synchronized change lands exactly in the RESP cycle of the write.
   task automatic collide(input logic [1:0] off, input logic [31:0] d, input logic [PW-1:0] v, input string name);
      logic [31:0] rd; int lat; logic pe;
      PortIn = v;
      access(1'b0, 1'b1, BASE + {28'd0, off, 2'b00}, d, 20, rd, lat, pe);
      model_write(off, d);
      model_pin(v);
      chk({name, " latency"}, 32'(lat), 32'(WS + 1));
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        vecs[15];
      logic [31:0] rd;
      int          lat;
      logic        pe;
      logic        seen_ready;

      vecs[0]  = '{1'b1, 1'b0, BASE + 32'h0, 32'h0,         32'h0,         32'h0,         "reset PORT_OUT"};
      vecs[1]  = '{1'b1, 1'b0, BASE + 32'h4, 32'h0,         32'h0,         32'h0,         "reset PORT_IN"};
      vecs[2]  = '{1'b1, 1'b0, BASE + 32'h8, 32'h0,         32'h0,         32'h0,         "reset STATUS"};
      vecs[3]  = '{1'b1, 1'b0, BASE + 32'hC, 32'h0,         32'h0,         32'h0,         "reset EDGE_CNT"};
      vecs[4]  = '{1'b0, 1'b1, BASE + 32'h0, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, "write PORT_OUT"};
      vecs[5]  = '{1'b1, 1'b0, BASE + 32'h0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, "readback PORT_OUT"};
      vecs[6]  = '{1'b1, 1'b0, BASE + 32'h3, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, "byte bits ignored"};
      vecs[7]  = '{1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 32'h0,         32'hDEAD_BEEF, "write PORT_IN ack"};
      vecs[8]  = '{1'b1, 1'b0, BASE + 32'h4, 32'h0,         32'h0,         32'hDEAD_BEEF, "PORT_IN unchanged"};
      vecs[9]  = '{1'b1, 1'b1, BASE + 32'h0, 32'h5555_AAAA, 32'h0,         32'h5555_AAAA, "rd+wr is write"};
      vecs[10] = '{1'b1, 1'b0, BASE + 32'h0, 32'h0,         32'h5555_AAAA, 32'h5555_AAAA, "rd+wr readback"};
      vecs[11] = '{1'b0, 1'b1, BASE + 32'hC, 32'h0,         32'h0,         32'h5555_AAAA, "clear EDGE_CNT"};
      vecs[12] = '{1'b1, 1'b0, BASE + 32'hC, 32'h0,         32'h0,         32'h5555_AAAA, "EDGE_CNT after clear"};
      vecs[13] = '{1'b0, 1'b1, BASE + 32'h9, 32'h1,         32'h0,         32'h5555_AAAA, "W1C idle STATUS"};
      vecs[14] = '{1'b1, 1'b0, BASE + 32'h8, 32'h0,         32'h0,         32'h5555_AAAA, "STATUS after W1C"};

      reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0; PortIn = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk("reset Ready", {31'd0, Ready}, 32'd0);
      chk("reset PortOut", PortOut, 32'd0);
`ifdef MMIO_PORT_IRQ_EN
      chk("reset irq", {31'd0, irq}, 32'd0);
`endif

      for (int i = 0; i < 15; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 20, rd, lat, pe);
         chk({vecs[i].name, " latency"}, 32'(lat), 32'(WS + 1));
         chk({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
         chk({vecs[i].name, " PortOut"}, PortOut, vecs[i].exp_pout);
         chk({vecs[i].name, " protocol"}, {31'd0, pe}, 32'd0);
      end
      m_port_out = 32'h5555_AAAA;

      // input change path
      set_pin(8'hA5);
      bus_read(BASE + 32'h4, 32'h0000_00A5, "PORT_IN A5");
      bus_read(BASE + 32'h8, 32'h1, "CHANGED set");
      bus_read(BASE + 32'hC, 32'h1, "EDGE_CNT one");
      bus_write(BASE + 32'h8, 32'h1, 1'b0, "W1C CHANGED");
      bus_read(BASE + 32'h8, 32'h0, "CHANGED cleared");
      set_pin(8'h5A);
      set_pin(8'hA5);
      set_pin(8'h5A);
      bus_read(BASE + 32'hC, 32'h4, "EDGE_CNT four");

      // unselected request held for 10 cycles
      access(1'b1, 1'b0, 32'h1002_0000, 32'h0, 10, rd, lat, pe);
      chk("unselected no Ready", 32'(lat), 32'hFFFF_FFFF);
      bus_read(BASE + 32'h0, 32'h5555_AAAA, "unsel PORT_OUT kept");
      bus_read(BASE + 32'h8, 32'h1, "unsel STATUS kept");
      bus_read(BASE + 32'hC, 32'h4, "unsel EDGE_CNT kept");

      // collisions: set beats W1C, change beats counter clear
      bus_write(BASE + 32'h8, 32'h3, 1'b0, "clear+enable");
      bus_read(BASE + 32'h8, exp_reg(2'd2), "STATUS before collision");
      collide(2'd2, 32'h1, 8'h3C, "W1C collision");
      bus_read(BASE + 32'h8, exp_reg(2'd2), "collision CHANGED");
      chk("collision CHANGED bit", {31'd0, m_changed}, 32'd1);
`ifdef MMIO_PORT_IRQ_EN
      chk("collision irq", {31'd0, irq}, 32'd1);
`endif
      collide(2'd3, 32'h0, 8'hC3, "clear collision");
      bus_read(BASE + 32'hC, 32'h1, "EDGE_CNT clear collision");

      // randomized traffic against the model
      for (int it = 0; it < 250; it++) begin
         int          op;
         logic [1:0]  off;
         logic [31:0] a, d;
         op  = $urandom_range(0, 9);
         off = 2'($urandom_range(0, 3));
         a   = BASE + {28'd0, off, 2'($urandom_range(0, 3))};
         d   = $urandom;
         if (op <= 1) begin
            set_pin(PW'($urandom));
         end else if (op <= 4) begin
            bus_write(a, d, 1'($urandom_range(0, 1)), "rand write");
         end else if (op <= 8) begin
            bus_read(a, exp_reg(off), "rand read");
`ifdef MMIO_PORT_IRQ_EN
            chk("rand irq", {31'd0, irq}, {31'd0, m_changed & m_irq_en});
`endif
         end else begin
            a = BASE ^ {28'($urandom_range(1, 268435455)), 4'h0};
            access(1'b1, 1'($urandom_range(0, 1)), a, d, 4, rd, lat, pe);
            chk("rand unselected", 32'(lat), 32'hFFFF_FFFF);
         end
      end

      // reset in the middle of a pending write
      bus_write(BASE + 32'h0, 32'hCAFE_F00D, 1'b0, "pre-reset write");
      set_pin('0);
      @(negedge clk);
      MemWrite = 1'b1; Address = BASE; WriteData = 32'h0000_1234;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("mid reset Ready", {31'd0, Ready}, 32'd0);
      chk("mid reset PortOut", PortOut, 32'd0);
      MemWrite = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (Ready) seen_ready = 1'b1;
      end
      chk("post reset no Ready", {31'd0, seen_ready}, 32'd0);
      chk("post reset PortOut", PortOut, 32'd0);
      bus_read(BASE + 32'h0, 32'h0, "post reset PORT_OUT");
      bus_read(BASE + 32'h8, 32'h0, "post reset STATUS");
      bus_read(BASE + 32'hC, 32'h0, "post reset EDGE_CNT");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the MIPS data-bus side; the processor's load/store path is the initiator.
- Owns the PortOut register and a synchronized view of PortIn.
- Adds a sticky input-change flag and an input-change counter.
- Responds over a request/ready handshake with a programmable number of wait states, so the core can stall on I/O.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte base of the 16-byte register window; bits [3:0] must be 0.
- WAIT_STATES, 1, extra cycles between request acceptance and Ready; legal range 0..15.
- PORT_IN_WIDTH, 8, width of PortIn.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemRead  input  1  read request, held by the initiator until Ready.
- MemWrite  input  1  write request, held by the initiator until Ready.
- Address  input  32  byte address of the access.
- WriteData  input  32  store data.
- ReadData  output  32  load data, valid only while Ready=1.
- Ready  output  1  one-cycle completion strobe.
- PortIn  input  PORT_IN_WIDTH  external asynchronous input pins.
- PortOut  output  32  output port register.

Behaviour:
- Decode: Sel = (Address[31:4] == BASE_ADDR[31:4]); register offset = Address[3:2]; Address[1:0] ignored.
- Requests with Sel=0 get no response; Ready stays 0.
- Register map:
  - 0x0 PORT_OUT: R/W, 32 bits, drives PortOut directly.
  - 0x4 PORT_IN: RO, zero-extended synchronized PortIn.
  - 0x8 STATUS: bit0 CHANGED is sticky; writing 1 to bit0 clears it; other bits read 0.
  - 0xC EDGE_CNT: RO 16-bit count, zero-extended; saturates at 0xFFFF; any write clears it to 0.
  - Writes to PORT_IN are ignored but still acknowledged.
- FSM states IDLE, WAIT, RESP, GAP:
  - IDLE: on Sel & (MemRead|MemWrite), latch offset, op and data. Go to RESP if WAIT_STATES==0; otherwise go to WAIT with count = WAIT_STATES-1.
  - WAIT: decrement count each cycle; go to RESP when count==0.
  - RESP: Ready=1 for exactly one cycle; write takes effect at the end of this cycle; ReadData = addressed register value during this cycle. Next state GAP.
  - GAP: one cycle; requests are ignored. Next state IDLE. The initiator must drop its request in the cycle after Ready.
- Latency: Ready rises WAIT_STATES+1 cycles after the request is first sampled in IDLE.
- ReadData is 0 whenever Ready=0.
- MemRead and MemWrite both high: treated as a write; ReadData=0 during RESP.
- Input path:
  - PortIn goes through a 2-flop synchronizer, giving sync2.
  - prev register holds the last sync2 value.
  - Change = (sync2 != prev); it sets CHANGED and increments EDGE_CNT on the following edge.
  - Timing: PortIn change at edge N → PORT_IN value updates at N+2, CHANGED=1 at N+3.
- Collisions:
  - Change event and W1C of CHANGED in the same cycle: set wins, CHANGED stays 1.
  - Change event and EDGE_CNT clear in the same cycle: result is 1.
- Reset (any time, including mid-transaction): FSM→IDLE; Ready=0; ReadData=0; PortOut=0; CHANGED=0; EDGE_CNT=0; synchronizer and prev=0. Any in-flight write is discarded.

Optional Feature:
- Macro: MMIO_PORT_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, reset 0).
  - Adds register 0x8 bit1 IRQ_ENABLE (R/W, reset 0); W1C on bit0 is unaffected by the bit1 value written.
  - irq = CHANGED & IRQ_ENABLE, registered, so it asserts one cycle after both are true.
- Undefined: no irq port; STATUS bit1 reads 0 and writes to it are ignored.

Test Plan:
- Reset values: after reset release → PortOut=0, Ready=0, reads of 0x8 and 0xC return 0.
- Write latency: WAIT_STATES=1; MemWrite to 0x1001_0000 with 0xDEAD_BEEF → Ready at the 2nd edge after request, PortOut=0xDEADBEEF on the following cycle. Readback of 0x0 returns 0xDEADBEEF.
- Input change: PortIn 0x00→0xA5 → read 0x4 returns 0x000000A5, 0x8 returns 1, 0xC returns 1.
  - Write 0x1 to 0x8 → 0x8 reads 0.
  - Toggle PortIn 3 more times → 0xC reads 4.
- Unselected access: MemRead to 0x1002_0000 held 10 cycles → Ready never asserts, all registers unchanged.
- Reset mid-transaction: assert reset during WAIT with a pending write of 0x1234 → after release, FSM is IDLE, PortOut=0, no Ready pulse.
- Collision: PortIn change on the same cycle as a W1C write to 0x8 → CHANGED=1. With MMIO_PORT_IRQ_EN and IRQ_ENABLE=1 → irq=1.
